// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_tx arbiter slice.
package uart_arb_pkg;

    localparam int UART_ARB_MAX_REQ = 8;

    typedef enum logic [1:0] {
        ARB,
        ISSUE,
        WAIT_START,
        WAIT_DONE
    } arb_state_t;

    // Index of the requester after idx, wrapping n-1 -> 0.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req searching from ptr upward, modulo N.
module rr_pick #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] index,
    output logic         any
);

    int k;

    // NOTE: every output gets a default before the loop so no path leaves a value unassigned, which would infer a latch.
    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        k     = 0;
        // Walk from the farthest offset down so the closest match to ptr is the last write.
        for (int off = N - 1; off >= 0; off--) begin
            k = (int'(ptr) + off) % N;
            if (req[k]) begin
                grant    = '0;
                grant[k] = 1'b1;
                index    = W'(k);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locking scheduler sharing one uart_tx between NUM_REQ byte streams.
// Define UART_ARB_TIMEOUT_EN to revoke a lock whose owner stays idle for TIMEOUT_CYCLES.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int TIMEOUT_CYCLES = 65535,
    localparam int W              = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [NUM_REQ*8-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]   i_req_last,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_dv,
    input  logic                 i_tx_active,
    output logic [W-1:0]         o_grant_id,
    output logic                 o_locked,
    output logic                 o_timeout
);

    arb_state_t   state_q, state_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] grant_q, grant_d;
    logic         locked_q, locked_d;
    logic [7:0]   tx_data_q, tx_data_d;
    logic         tx_dv_q, tx_dv_d;
`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0]  cnt_q, cnt_d;
    logic         timeout_q, timeout_d;
`endif

    logic [NUM_REQ-1:0] pick_grant;
    logic [W-1:0]       pick_index;
    logic               pick_any;
    logic [NUM_REQ-1:0] req_ready;
    logic [W-1:0]       winner;
    logic [7:0]         win_data;
    logic               win_last;
    logic               accept;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (i_req_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .index (pick_index),
        .any   (pick_any)
    );

    always_comb begin
        req_ready = '0;
        if (state_q == ARB) begin
            if (locked_q) req_ready[grant_q] = 1'b1;
            else          req_ready = pick_grant;
        end
    end

    assign accept = |(i_req_valid & req_ready);
    assign winner = locked_q ? grant_q : pick_index;

    always_comb begin
        win_data = '0;
        win_last = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (winner == W'(r)) begin
                win_data = i_req_data[r*8 +: 8];
                win_last = i_req_last[r];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        locked_d  = locked_q;
        tx_data_d = tx_data_q;
        tx_dv_d   = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ARB: begin
                if (accept) begin
                    tx_data_d = win_data;
                    grant_d   = winner;
                    tx_dv_d   = 1'b1;
                    state_d   = ISSUE;
                    locked_d  = !win_last;
                    if (win_last) ptr_d = W'(wrap_inc(int'(winner), NUM_REQ));
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d = '0;
                end else if (locked_q) begin
                    // Owner is idle here, otherwise its byte would have been accepted.
                    if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                        locked_d  = 1'b0;
                        ptr_d     = W'(wrap_inc(int'(grant_q), NUM_REQ));
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
`endif
                end
            end
            ISSUE:      state_d = WAIT_START;
            WAIT_START: if (i_tx_active)  state_d = WAIT_DONE;
            WAIT_DONE:  if (!i_tx_active) state_d = ARB;
            default:    state_d = ARB;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB;
            ptr_q     <= '0;
            grant_q   <= '0;
            locked_q  <= 1'b0;
            tx_data_q <= '0;
            tx_dv_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            locked_q  <= locked_d;
            tx_data_q <= tx_data_d;
            tx_dv_q   <= tx_dv_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign o_req_ready = req_ready;
    assign o_tx_data   = tx_data_q;
    assign o_tx_dv     = tx_dv_q;
    assign o_grant_id  = grant_q;
    assign o_locked    = locked_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign o_timeout   = timeout_q;
`else
    assign o_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx busy model (10 bits x 4 clocks).
module tb_uart_tx_arbiter;

    localparam int N          = 4;
    localparam int FRAME_CLKS = 40;
    localparam int BUDGET     = 3000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   i_req_valid = '0;
    logic [N*8-1:0] i_req_data  = '0;
    logic [N-1:0]   i_req_last  = '0;
    logic [N-1:0]   o_req_ready;
    logic [7:0]     o_tx_data;
    logic           o_tx_dv;
    logic           i_tx_active;
    logic [1:0]     o_grant_id;
    logic           o_locked;
    logic           o_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(20)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .i_req_last  (i_req_last),
        .o_req_ready (o_req_ready),
        .o_tx_data   (o_tx_data),
        .o_tx_dv     (o_tx_dv),
        .i_tx_active (i_tx_active),
        .o_grant_id  (o_grant_id),
        .o_locked    (o_locked),
        .o_timeout   (o_timeout)
    );

    // uart_tx stand-in: goes busy the cycle after the start pulse and stays busy for one frame.
    int busy_cnt;
    always @(posedge clk) begin
        if (rst)                busy_cnt <= 0;
        else if (o_tx_dv)       busy_cnt <= FRAME_CLKS;
        else if (busy_cnt > 0)  busy_cnt <= busy_cnt - 1;
    end
    assign i_tx_active = (busy_cnt != 0);

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic [10:0] sb [$];        // {locked, grant_id, byte} expected at each start pulse
    logic [8:0]  dq [N][$];     // per-requester {last, byte} stimulus
    logic [N-1:0] hs = '0;

    task automatic expect_tx(input logic lk, input int id, input logic [7:0] d);
        sb.push_back({lk, 2'(id), d});
    endtask

    task automatic load(input int r, input logic last, input logic [7:0] d);
        dq[r].push_back({last, d});
    endtask

    function automatic int pending();
        int p = 0;
        for (int r = 0; r < N; r++) p += dq[r].size();
        return p;
    endfunction

    // Driver: present queue heads at negedge, sample the handshake just before the posedge.
    initial begin : driver
        logic [8:0] h;
        forever begin
            @(negedge clk);
            for (int r = 0; r < N; r++)
                if (hs[r] && dq[r].size() > 0) void'(dq[r].pop_front());
            for (int r = 0; r < N; r++) begin
                if (dq[r].size() > 0) begin
                    h = dq[r][0];
                    i_req_valid[r]        = 1'b1;
                    i_req_data[r*8 +: 8]  = h[7:0];
                    i_req_last[r]         = h[8];
                end else begin
                    i_req_valid[r]        = 1'b0;
                    i_req_data[r*8 +: 8]  = 8'h00;
                    i_req_last[r]         = 1'b0;
                end
            end
            #4;
            hs = i_req_valid & o_req_ready & {N{~rst}};
        end
    end

    // Monitor: each start pulse pops one expected transfer.
    int   timeout_pulses = 0;
    logic lock_seen      = 1'b0;
    logic busy_ready     = 1'b0;
    logic [10:0] exp_e;
    always @(negedge clk) begin
        if (!rst) begin
            if (o_timeout) timeout_pulses++;
            if (o_locked) lock_seen = 1'b1;
            if (i_tx_active && (o_req_ready != '0)) busy_ready = 1'b1;
            if (o_tx_dv) begin
                if (sb.size() == 0) begin
                    check("unexpected_tx", {21'd0, o_locked, o_grant_id, o_tx_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_e = sb.pop_front();
                    check("tx_byte", {21'd0, o_locked, o_grant_id, o_tx_data}, {21'd0, exp_e});
                    check("tx_idle_at_dv", {31'd0, i_tx_active}, 32'd0);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || pending() != 0 || i_tx_active || o_tx_dv) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, n < BUDGET}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_active(input logic level);
        int n = 0;
        while (i_tx_active !== level && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("wait_active", {31'd0, n < BUDGET}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},   {28'd0, o_req_ready}, 32'd0);
        check({tag, "_dv"},      {31'd0, o_tx_dv},     32'd0);
        check({tag, "_data"},    {24'd0, o_tx_data},   32'd0);
        check({tag, "_grant"},   {30'd0, o_grant_id},  32'd0);
        check({tag, "_locked"},  {31'd0, o_locked},    32'd0);
        check({tag, "_timeout"}, {31'd0, o_timeout},   32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic ready3_seen;
        int   n;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single byte from req0: unlocked, id 0, data held afterwards.
        lock_seen = 1'b0;
        expect_tx(1'b0, 0, 8'h55);
        load(0, 1'b1, 8'h55);
        drain("single_drain");
        check("single_no_lock", {31'd0, lock_seen}, 32'd0);
        check("single_data_hold", {24'd0, o_tx_data}, 32'h55);

        // Round robin over two rounds with all four requesters valid.
        do_reset();
        for (int r = 0; r < N; r++) begin
            load(r, 1'b1, 8'hA0 + 8'(r));
            load(r, 1'b1, 8'hB0 + 8'(r));
        end
        for (int r = 0; r < N; r++) expect_tx(1'b0, r, 8'hA0 + 8'(r));
        for (int r = 0; r < N; r++) expect_tx(1'b0, r, 8'hB0 + 8'(r));
        drain("rr_drain");
        check("rr_ready_while_busy", {31'd0, busy_ready}, 32'd0);

        // Message lock: "HI\n" from req1 is not interleaved with req2.
        do_reset();
        load(1, 1'b0, 8'h48);
        load(1, 1'b0, 8'h49);
        load(1, 1'b1, 8'h0A);
        load(2, 1'b1, 8'h21);
        expect_tx(1'b1, 1, 8'h48);
        expect_tx(1'b1, 1, 8'h49);
        expect_tx(1'b0, 1, 8'h0A);
        expect_tx(1'b0, 2, 8'h21);
        drain("lock_drain");

        // Owner stall: req0 locked, then idle while req3 waits.
        do_reset();
        timeout_pulses = 0;
        load(0, 1'b0, 8'h31);
        load(3, 1'b1, 8'hC3);
        expect_tx(1'b1, 0, 8'h31);
`ifdef UART_ARB_TIMEOUT_EN
        expect_tx(1'b0, 3, 8'hC3);
`endif
        wait_active(1'b1);
        wait_active(1'b0);
        ready3_seen = 1'b0;
        n = 0;
        repeat (50) begin
            @(negedge clk);
            if (o_req_ready[3]) ready3_seen = 1'b1;
        end
        load(0, 1'b1, 8'h32);
        expect_tx(1'b0, 0, 8'h32);
`ifndef UART_ARB_TIMEOUT_EN
        expect_tx(1'b0, 3, 8'hC3);
`endif
        drain("stall_drain");
`ifdef UART_ARB_TIMEOUT_EN
        check("stall_ready3", {31'd0, ready3_seen}, 32'd1);
        check("stall_timeouts", timeout_pulses, 32'd1);
`else
        check("stall_ready3", {31'd0, ready3_seen}, 32'd0);
        check("stall_timeouts", timeout_pulses, 32'd0);
`endif

        // Reset during WAIT_DONE abandons the byte; a new byte then goes out normally.
        do_reset();
        load(0, 1'b1, 8'hFF);
        expect_tx(1'b0, 0, 8'hFF);
        wait_active(1'b1);
        repeat (5) @(negedge clk);
        do_reset();
        check_reset_outputs("midreset");
        check("midreset_line_idle", {31'd0, i_tx_active}, 32'd0);
        load(2, 1'b1, 8'h0F);
        expect_tx(1'b0, 2, 8'h0F);
        drain("midreset_drain");

        // Pointer wrap: after req3, search restarts at req0.
        do_reset();
        load(3, 1'b1, 8'h33);
        expect_tx(1'b0, 3, 8'h33);
        n = 0;
        while (dq[3].size() != 0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        load(0, 1'b1, 8'h10);
        load(2, 1'b1, 8'h12);
        expect_tx(1'b0, 0, 8'h10);
        expect_tx(1'b0, 2, 8'h12);
        drain("wrap_drain");

        check("end_ready_while_busy", {31'd0, busy_ready}, 32'd0);
        check("end_sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one uart_tx serializer between NUM_REQ byte-stream requesters.
- Each requester presents bytes on a valid/ready interface with a message-end flag.
- A granted requester keeps the serializer until it sends its last byte, so messages from different sources never interleave on the wire.
- Sits between debug/console sources (CPU MMIO port, trace unit, etc.) and uart_tx; drives its i_tx_dv/i_tx_data and monitors its o_tx_active.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 65535, idle cycles before a held lock is revoked (used only with UART_ARB_TIMEOUT_EN).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- i_req_valid  input  NUM_REQ  per-requester byte valid.
- i_req_data  input  NUM_REQ*8  per-requester byte; requester k uses bits [8k+7:8k].
- i_req_last  input  NUM_REQ  byte is last of message; qualified by valid.
- o_req_ready  output  NUM_REQ  one-hot or zero; byte accepted when valid&ready.
- o_tx_data  output  8  registered byte to uart_tx.
- o_tx_dv  output  1  one-cycle start pulse to uart_tx.
- i_tx_active  input  1  uart_tx busy flag.
- o_grant_id  output  $clog2(NUM_REQ)  current/last owner index.
- o_locked  output  1  a message is in progress.
- o_timeout  output  1  one-cycle pulse when a lock is revoked.

Behaviour:
- Reset values (sync, active-high):
  - state=ARB, o_tx_dv=0, o_tx_data=0, o_req_ready=0, o_grant_id=0, o_locked=0, o_timeout=0.
  - RR pointer=0, timeout counter=0.
  - Reset mid-frame abandons the byte; the same rst also resets uart_tx.
- State ARB:
  - Locked: o_req_ready[owner]=1 only.
  - Unlocked: o_req_ready[w]=1, where w is the first valid index searching ptr, ptr+1, ... (mod NUM_REQ). If none are valid, all ready=0.
  - o_req_ready is combinational from state, lock, ptr and i_req_valid.
- On accept (cycle t):
  - Latch data into o_tx_data; o_grant_id=winner.
  - If last=0: o_locked=1 (owner=winner).
  - If last=1: o_locked=0, ptr=winner+1 mod NUM_REQ.
  - Go to ISSUE.
- ISSUE (t+1): o_tx_dv=1 for exactly this cycle; go to WAIT_START.
- WAIT_START: stay until i_tx_active=1 (expected t+2), then go to WAIT_DONE.
- WAIT_DONE: stay until i_tx_active=0, then go to ARB.
- o_req_ready=0 in every state other than ARB. At most one byte is in flight; there is no internal FIFO.
- o_tx_data holds its value until the next accept.
- Simultaneous valid on several requesters, unlocked: only the RR winner gets ready. Others wait; their data must stay stable.
- Locked owner drops valid: arbiter waits in ARB and other requesters are starved (subject to the optional timeout).
- A single-byte message (last=1 on first byte) never sets o_locked.
- Pointer wraps NUM_REQ-1 -> 0.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- With macro:
  - In ARB while locked, a 16-bit counter increments each cycle the owner's valid=0 and clears on accept.
  - When it reaches TIMEOUT_CYCLES-1: clear lock, ptr=owner+1 mod NUM_REQ, pulse o_timeout for 1 cycle, clear counter.
  - Arbitration resumes on the next cycle.
- Without macro:
  - No counter is present.
  - A lock is held indefinitely.
  - o_timeout is tied 0.

Decomposition:
- Package uart_arb_pkg:
  - arb_state_t enum {ARB, ISSUE, WAIT_START, WAIT_DONE}, logic [1:0].
  - UART_ARB_MAX_REQ=8.
- Sub-module rr_pick (combinational):
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, index, any.
  - Reusable by other shared-resource arbiters.

Test Plan:
- Single requester, unlocked: req0 sends 0x55 with last=1 -> ready0 at t, o_tx_dv high at t+1 with o_tx_data=0x55. The 10-bit serial frame at CLKS_PER_BIT=4 is 0,1,0,1,0,1,0,1,0,1. o_locked stays 0.
- Round robin: req0..req3 all valid, single bytes 0xA0..0xA3, last=1 -> wire order A0, A1, A2, A3. Second round starts at req0 again, and no byte is accepted while i_tx_active=1.
- Message lock: req1 sends "HI\n" (0x48,0x49,0x0A with last on 0x0A) while req2 continuously valid 0x21 -> wire order 48, 49, 0A, 21. o_locked is high from after 0x48 until 0x0A is accepted.
- Owner stall: req0 locked after 0x31, valid low for 50 cycles while req3 valid -> o_req_ready stays 0 for req3. With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=20: o_timeout pulses once, then req3's byte is sent and ptr=1.
- Reset mid-operation: assert rst during WAIT_DONE of byte 0xFF -> next cycle state=ARB, all outputs at reset values, serial line idle high. A new byte 0x0F afterwards transmits correctly.
- Pointer wrap, NUM_REQ=4: last message from req3 -> next grant search starts at req0. With req0 and req2 valid, req0 wins.
